// File: rtl/exec_pkg.sv
// Execute-stage shared definitions: ALU op codes, op width and multicycle classification.
package exec_pkg;

   localparam int ALU_OP_W = 4;

   localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
   localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
   localparam logic [ALU_OP_W-1:0] ALU_MUL = 4'd2;
   localparam logic [ALU_OP_W-1:0] ALU_DIV = 4'd3;
   localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd4;
   localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd5;
   localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd6;
   localparam logic [ALU_OP_W-1:0] ALU_MOD = 4'd7;

   function automatic logic is_multicycle(input logic [ALU_OP_W-1:0] op);
      return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_MOD);
   endfunction

endpackage

// File: rtl/ex_hazard_detect.sv
// Load-use hazard detection between the load resident in EX and the ID candidate.
module ex_hazard_detect
   import exec_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_imm,
   input  logic              id_mem_write,
   output logic              load_use
);

   logic rt_used;
   logic rs_hit;
   logic rt_hit;

   // Stores read rt as data even when B is the immediate.
   assign rt_used = !id_use_imm || id_mem_write;
   assign rs_hit  = (id_rs == ex_rd);
   assign rt_hit  = rt_used && (id_rt == ex_rd);

   assign load_use = ex_valid && ex_mem_read && (ex_rd != '0)
                     && id_valid && (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with load-use bubbles
// and multicycle mul/div/mod occupancy.
module id_ex_stage
   import exec_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 5,
   parameter int OP_W       = ALU_OP_W,
   parameter int MULDIV_LAT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [OP_W-1:0]   id_op,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_rs_val,
   input  logic [DATA_W-1:0] id_rt_val,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_use_imm,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              mem_stall,
   input  logic              flush,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic [DATA_W-1:0] ex_store_data,
   output logic              ex_valid,
   output logic              ex_done,
   output logic              ex_div_zero,
   output logic              stall_out
);

   localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic             load_use;
   logic             id_multi;

   ex_hazard_detect #(
      .REG_AW(REG_AW)
   ) u_hazard (
      .ex_valid    (ex_valid),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_imm  (id_use_imm),
      .id_mem_write(id_mem_write),
      .load_use    (load_use)
   );

   assign busy     = (cnt != '0);
   assign id_multi = id_valid && is_multicycle(id_op);

   assign stall_out = !rst && !flush && (mem_stall || busy || load_use);
   assign ex_done   = ex_valid && !busy && !mem_stall;

   assign ex_div_zero = ex_valid
                        && ((alu_op == ALU_DIV) || (alu_op == ALU_MOD))
                        && (alu_b == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_op        <= '0;
         alu_a         <= '0;
         alu_b         <= '0;
         ex_rd         <= '0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_store_data <= '0;
         ex_valid      <= 1'b0;
         cnt           <= '0;
      end else if (flush) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         cnt          <= '0;
      end else if (!mem_stall) begin
         if (busy) begin
            cnt <= cnt - CNT_W'(1);
         end else if (load_use) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            cnt          <= '0;
         end else begin
            alu_op        <= id_op;
            alu_a         <= id_rs_val;
            alu_b         <= id_use_imm ? id_imm : id_rt_val;
            ex_rd         <= id_rd;
            ex_store_data <= id_rt_val;
            ex_valid      <= id_valid;
            ex_reg_write  <= id_valid && id_reg_write && (id_rd != '0);
            ex_mem_read   <= id_valid && id_mem_read;
            ex_mem_write  <= id_valid && id_mem_write;
            cnt           <= id_multi ? CNT_LOAD : '0;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [3:0]  id_op;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rs_val, id_rt_val, id_imm;
   logic        id_use_imm, id_reg_write, id_mem_read, id_mem_write;
   logic        mem_stall, flush;
   logic [3:0]  alu_op;
   logic [31:0] alu_a, alu_b, ex_store_data;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_mem_read, ex_mem_write;
   logic        ex_valid, ex_done, ex_div_zero, stall_out;

   int checks = 0;
   int errors = 0;
   int first;

   always #5 clk = ~clk;

   id_ex_stage #(
      .DATA_W(32), .REG_AW(5), .OP_W(4), .MULDIV_LAT(4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_op        (id_op),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rd        (id_rd),
      .id_rs_val    (id_rs_val),
      .id_rt_val    (id_rt_val),
      .id_imm       (id_imm),
      .id_use_imm   (id_use_imm),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .id_mem_write (id_mem_write),
      .mem_stall    (mem_stall),
      .flush        (flush),
      .alu_op       (alu_op),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .ex_rd        (ex_rd),
      .ex_reg_write (ex_reg_write),
      .ex_mem_read  (ex_mem_read),
      .ex_mem_write (ex_mem_write),
      .ex_store_data(ex_store_data),
      .ex_valid     (ex_valid),
      .ex_done      (ex_done),
      .ex_div_zero  (ex_div_zero),
      .stall_out    (stall_out)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsv,
                        input logic [31:0] rtv, input logic [31:0] imm,
                        input logic ui, input logic rw,
                        input logic mr, input logic mw);
      id_valid = v;  id_op = op;  id_rs = rs;  id_rt = rt;  id_rd = rd;
      id_rs_val = rsv;  id_rt_val = rtv;  id_imm = imm;
      id_use_imm = ui;  id_reg_write = rw;
      id_mem_read = mr;  id_mem_write = mw;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1;
      mem_stall = 1'b0;
      flush = 1'b0;
      idle();
      step();
      step();
      check("rst_valid", 32'(ex_valid), 0);
      check("rst_stall", 32'(stall_out), 0);
      check("rst_done", 32'(ex_done), 0);
      check("rst_a", alu_a, 0);
      rst = 1'b0;

      // ADD with immediate
      step();
      drive(1, 0, 1, 2, 3, 5, 9, 7, 1, 1, 0, 0);
      #1 check("add_stall_id", 32'(stall_out), 0);
      step();
      idle();
      #1;
      check("add_op", 32'(alu_op), 0);
      check("add_a", alu_a, 5);
      check("add_b", alu_b, 7);
      check("add_done", 32'(ex_done), 1);
      check("add_rw", 32'(ex_reg_write), 1);
      check("add_stall", 32'(stall_out), 0);

      // load-use
      step();
      drive(1, 0, 1, 0, 8, 100, 0, 4, 1, 1, 1, 0);
      step();
      drive(1, 0, 2, 8, 9, 11, 0, 1, 1, 1, 0, 0);
      #1 check("lu_rt_imm", 32'(stall_out), 0);
      id_use_imm = 1'b0;
      #1 check("lu_rt_reg", 32'(stall_out), 1);
      drive(1, 0, 8, 0, 9, 11, 0, 1, 1, 1, 0, 0);
      #1;
      check("lu_stall", 32'(stall_out), 1);
      check("lu_ex_load", 32'(ex_mem_read), 1);
      step();
      check("lu_bubble", 32'(ex_valid), 0);
      check("lu_bubble_rw", 32'(ex_reg_write), 0);
      check("lu_stall_end", 32'(stall_out), 0);
      step();
      idle();
      #1;
      check("lu_cap_valid", 32'(ex_valid), 1);
      check("lu_cap_a", alu_a, 11);
      check("lu_cap_rd", 32'(ex_rd), 9);

      // MUL 6*7 with a follower in ID
      step();
      drive(1, 2, 1, 2, 5, 6, 7, 0, 0, 1, 0, 0);
      step();
      drive(1, 0, 3, 0, 6, 1, 0, 1, 1, 1, 0, 0);
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("mul_stall%0d", k), 32'(stall_out), (k < 3) ? 1 : 0);
         check($sformatf("mul_done%0d", k), 32'(ex_done), (k == 3) ? 1 : 0);
         check($sformatf("mul_a%0d", k), alu_a, 6);
         check($sformatf("mul_b%0d", k), alu_b, 7);
         step();
      end
      idle();
      #1;
      check("mul_next_op", 32'(alu_op), 0);
      check("mul_next_a", alu_a, 1);

      // flush during DIV
      step();
      drive(1, 3, 1, 2, 7, 20, 4, 0, 0, 1, 0, 0);
      step();
      drive(1, 0, 3, 0, 10, 9, 0, 1, 1, 1, 0, 0);
      step();
      #1 check("div_busy", 32'(stall_out), 1);
      flush = 1'b1;
      #1;
      check("flush_stall", 32'(stall_out), 0);
      check("flush_done", 32'(ex_done), 0);
      step();
      flush = 1'b0;
      #1;
      check("flush_valid", 32'(ex_valid), 0);
      check("flush_rw", 32'(ex_reg_write), 0);
      check("flush_stall2", 32'(stall_out), 0);
      step();
      idle();
      #1;
      check("flush_next_v", 32'(ex_valid), 1);
      check("flush_next_a", alu_a, 9);
      check("flush_next_done", 32'(ex_done), 1);

      step();
      drive(1, 7, 1, 2, 4, 13, 0, 5, 0, 1, 0, 0);
      step();
      idle();
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("mod_dz%0d", k), 32'(ex_div_zero), 1);
         check($sformatf("mod_done%0d", k), 32'(ex_done), (k == 3) ? 1 : 0);
         step();
      end
      check("mod_after_dz", 32'(ex_div_zero), 0);

      // write to x0 suppressed
      drive(1, 0, 1, 2, 0, 3, 0, 1, 1, 1, 0, 0);
      step();
      idle();
      #1;
      check("x0_valid", 32'(ex_valid), 1);
      check("x0_rw", 32'(ex_reg_write), 0);

      // op 12 passes through as single-cycle; store data carried
      drive(1, 12, 1, 2, 3, 21, 32'h55, 8, 1, 0, 0, 1);
      step();
      idle();
      #1;
      check("op12_op", 32'(alu_op), 12);
      check("op12_done", 32'(ex_done), 1);
      check("op12_stall", 32'(stall_out), 0);
      check("st_data", ex_store_data, 32'h55);
      check("st_b", alu_b, 8);
      check("st_mw", 32'(ex_mem_write), 1);

      // mem_stall for 2 cycles mid-MUL delays ex_done by 2
      step();
      drive(1, 2, 1, 2, 5, 3, 4, 0, 0, 1, 0, 0);
      step();
      idle();
      first = -1;
      for (int k = 0; k < 10; k++) begin
         if (k == 1) mem_stall = 1'b1;
         if (k == 3) mem_stall = 1'b0;
         #1;
         if (k == 2) check("ms_stall", 32'(stall_out), 1);
         if (ex_done && first < 0) first = k;
         step();
      end
      check("ms_done_cycle", 32'(first), 5);

      // async reset mid-MUL
      drive(1, 2, 1, 2, 5, 6, 7, 0, 0, 1, 0, 0);
      step();
      idle();
      step();
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(ex_valid), 0);
      check("arst_op", 32'(alu_op), 0);
      check("arst_a", alu_a, 0);
      check("arst_b", alu_b, 0);
      check("arst_stall", 32'(stall_out), 0);
      check("arst_done", 32'(ex_done), 0);
      step();
      rst = 1'b0;
      step();
      check("arst_after_stall", 32'(stall_out), 0);
      check("arst_after_valid", 32'(ex_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
